// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver.
// Frame format: start(0), 8 data bits LSB first, optional parity bit, stop(1).
// Each bit is resolved by a 2-of-3 majority around its midpoint. Each frame
// produces exactly one one-cycle result pulse (valid, parity error and/or stop error).
module uart_rx_frame #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [7:0] P_DATA,
  output logic       Data_Valid,
  output logic       Parity_Error,
  output logic       Stop_Error,
  output logic       busy
);

  localparam int unsigned EW = $clog2(OVERSAMPLE);
  localparam logic [EW-1:0] CNT_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [EW-1:0] CNT_S0   = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] CNT_S1   = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] CNT_S2   = EW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    samp_q, samp_d;
  logic          par_en_q, par_en_d;
  logic          par_typ_q, par_typ_d;
  logic          par_bit_q, par_bit_d;
  logic [7:0]    pdata_q, pdata_d;
  logic          dv_q, dv_d;
  logic          pe_q, pe_d;
  logic          se_q, se_d;

  logic rx_s;
  logic maj;
  logic stop_decide;
  logic par_exp;
  logic par_bad;
  logic stop_bad;

  assign rx_s = sync_q[1];
  // The third sample is the live synchronized line at count H+1.
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign stop_decide = (state_q == STOP) && (edge_q == CNT_S2);

  // State register: all flops, asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      edge_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      samp_q    <= '1;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bit_q <= 1'b0;
      pdata_q   <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      samp_q    <= samp_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bit_q <= par_bit_d;
      pdata_q   <= pdata_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  // Next-state logic: synchronizer, counters, sampling and bit assembly
  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], RX_IN};
    edge_d    = edge_q;
    bit_d     = bit_q;
    data_d    = data_q;
    samp_d    = samp_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bit_d = par_bit_q;

    if (state_q != IDLE) begin
      edge_d = (edge_q == CNT_LAST) ? '0 : edge_q + EW'(1);
      if (edge_q == CNT_S0) samp_d[0] = rx_s;
      if (edge_q == CNT_S1) samp_d[1] = rx_s;
    end

    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!rx_s) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end
      end
      START: begin
        if ((edge_q == CNT_S2) && maj) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (edge_q == CNT_LAST) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (edge_q == CNT_S2) data_d[bit_q] = maj;
        if (edge_q == CNT_LAST) begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (edge_q == CNT_S2) par_bit_d = maj;
        if (edge_q == CNT_LAST) state_d = STOP;
      end
      STOP: begin
        // Leave at the stop midpoint so a start bit right after it is caught.
        if (edge_q == CNT_S2) begin
          state_d = IDLE;
          edge_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: frame verdict registered one cycle after the stop decision
  always_comb begin
    par_exp  = (^data_q) ^ par_typ_q;
    par_bad  = par_en_q && (par_bit_q != par_exp);
    stop_bad = !maj;
    dv_d     = 1'b0;
    pe_d     = 1'b0;
    se_d     = 1'b0;
    pdata_d  = pdata_q;
    if (stop_decide) begin
      if (!par_bad && !stop_bad) begin
        dv_d    = 1'b1;
        pdata_d = data_q;
      end else begin
        pe_d = par_bad;
        se_d = stop_bad;
      end
    end
    busy = (state_q != IDLE);
  end

  assign P_DATA       = pdata_q;
  assign Data_Valid   = dv_q;
  assign Parity_Error = pe_q;
  assign Stop_Error   = se_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame (OVERSAMPLE = 8). Expected frame outcomes are
// queued when a frame is sent and compared when a result pulse appears.
module tb_uart_rx_frame;

  localparam int unsigned OS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Stop_Error;
  logic       busy;

  uart_rx_frame #(.OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;  // {Data_Valid, Parity_Error, Stop_Error}
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle    = 0;
  int         dv_cycles[$];
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cycle++;

  // Result monitor: every pulse cycle must match the next queued outcome
  always @(negedge clk) begin
    if (!rst && (Data_Valid || Parity_Error || Stop_Error)) begin
      if (Data_Valid) dv_cycles.push_back(cycle);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: dv/pe/se=%b%b%b, required no pulse",
                 Data_Valid, Parity_Error, Stop_Error);
      end else begin
        e = exp_q.pop_front();
        if ({Data_Valid, Parity_Error, Stop_Error} !== e.flags) begin
          n_fail++;
          $display("FAIL pulse_flags: dv/pe/se=%b%b%b, required %b",
                   Data_Valid, Parity_Error, Stop_Error, e.flags);
        end
        n_checks++;
        if (P_DATA !== e.data) begin
          n_fail++;
          $display("FAIL pulse_pdata: P_DATA=%h, required %h", P_DATA, e.data);
        end
      end
    end
  end

  // Transmit one frame and queue its expected outcome
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic par_wrong, input logic stop_v, input logic flip);
    exp_t x;
    logic pe, se;
    pe = pen && par_wrong;
    se = !stop_v;
    x.flags = {!pe && !se, pe, se};
    if (!pe && !se) last_good = d;
    x.data = last_good;
    exp_q.push_back(x);
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    RX_IN   = 1'b0;
    repeat (OS) @(negedge clk);
    if (flip) begin
      PAR_EN  = !pen;
      PAR_TYP = !ptyp;
    end
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (OS) @(negedge clk);
    end
    if (pen) begin
      RX_IN = (^d) ^ ptyp ^ par_wrong;
      repeat (OS) @(negedge clk);
    end
    RX_IN = stop_v;
    repeat (OS) @(negedge clk);
    RX_IN = 1'b1;
  endtask

  // Bounded wait for all queued outcomes, then confirm quiet idle
  task automatic wait_idle(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (OS * 4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d outcomes pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_busy: busy=%b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #1;
    n_checks++;
    if ({Data_Valid, Parity_Error, Stop_Error} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: dv/pe/se=%b%b%b, required 000",
               Data_Valid, Parity_Error, Stop_Error);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (P_DATA !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_pdata: P_DATA=%h, required 00", P_DATA);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: busy=%b, required 0", busy);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_even_parity();
    send_frame(8'h0A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("even_parity");
  endtask

  task automatic test_parity_error();
    send_frame(8'h16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle("parity_error");
  endtask

  task automatic test_stop_error();
    send_frame(8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle("stop_error");
  endtask

  task automatic test_latched_config();
    // Inputs flipped mid-frame must not change how the frame is decoded
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_idle("latched_ok");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle("both_errors");
  endtask

  task automatic test_glitch();
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    RX_IN = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_rise: busy=%b, required 1", busy);
    end
    wait_idle("glitch");
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("after_glitch");
  endtask

  task automatic test_back_to_back();
    dv_cycles.delete();
    send_frame(8'h64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("back_to_back");
    n_checks++;
    if (dv_cycles.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_pulse_count: %0d valid pulses, required 2", dv_cycles.size());
    end else begin
      n_checks++;
      if (dv_cycles[1] - dv_cycles[0] != 80) begin
        n_fail++;
        $display("FAIL b2b_spacing: %0d clk, required 80", dv_cycles[1] - dv_cycles[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hFF;
    PAR_EN = 1'b0;
    RX_IN  = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX_IN = d[i];
      repeat (OS) @(negedge clk);
    end
    RX_IN = d[4];
    repeat (OS / 2) @(negedge clk);
    rst   = 1'b1;
    RX_IN = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_busy: busy=%b, required 0", busy);
    end
    n_checks++;
    if (P_DATA !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_pdata: P_DATA=%h, required 00", P_DATA);
    end
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_idle("mid_reset");
    send_frame(8'h23, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_parity_error();
    test_stop_error();
    test_latched_config();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
